appr_mac_prep: RTL
==================

Name: appr_mac_prep

Overview:
- Operand/mask preparation stage directly upstream of appr_wrapper (approximate signed multiplier).
- Latches a runtime configuration: effective operand widths and approximation level.
- Sign-extends raw operands to MAC_IN_WIDTH and emits res_mask/appr_mask aligned with each beat.
- Valid/ready stream with a 2-entry output buffer, so the multiplier needs no mask logic.

Parameters:
- MAC_IN_WIDTH, 9, multiplier operand width.
- N_BIT_APPR, 8, appr_mask width.
- N_BIT_RES, 14, res_mask width.
- MAC_OUT_WIDTH, 2*MAC_IN_WIDTH (localparam), full product width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when high with cfg_valid.
- cfg_eff_a  in  4  effective width of operand A, legal range 1..MAC_IN_WIDTH.
- cfg_eff_b  in  4  effective width of operand B, legal range 1..MAC_IN_WIDTH.
- cfg_level  in  N_BIT_APPR  approximation level.
- cfg_err  out  1  sticky: an illegal width was clamped.
- in_valid  in  1  raw operand beat valid.
- in_ready  out  1  stage can accept a beat.
- in_a  in  MAC_IN_WIDTH  raw A; only low eff_a bits meaningful.
- in_b  in  MAC_IN_WIDTH  raw B; only low eff_b bits meaningful.
- out_valid  out  1  beat available to the multiplier.
- out_ready  in  1  multiplier accepts the beat.
- out_a  out  MAC_IN_WIDTH  sign-extended A.
- out_b  out  MAC_IN_WIDTH  sign-extended B.
- out_res_mask  out  N_BIT_RES  result mask.
- out_appr_mask  out  N_BIT_APPR  approximation mask.
- beat_cnt  out  32  beats delivered (out handshakes), wraps at 2^32.

Behaviour:
- Reset (async, rst_n low): state=UNCFG; buffer empty; all outputs 0 except cfg_ready=1; stored config eff_a=eff_b=MAC_IN_WIDTH, level=0; cfg_err=0; beat_cnt=0.
- FSM states: UNCFG, RUN, DRAIN.
  - UNCFG: in_ready=0, cfg_ready=1. A cfg handshake goes to RUN.
  - RUN: in_ready = (occupancy<2); cfg_ready = (occupancy==0).
    - cfg_valid with occupancy==0: new config applied next cycle, stay in RUN.
    - cfg_valid with occupancy>0: go to DRAIN.
  - DRAIN: in_ready=0, cfg_ready=0. When occupancy reaches 0, return to RUN with cfg_ready=1; the pending config is taken by the normal handshake.
- Config clamp: cfg_eff_x==0 or >MAC_IN_WIDTH stores MAC_IN_WIDTH and sets cfg_err. cfg_err clears only on reset.
- Per-beat computation at input handshake, using the stored config:
  - out_a[i] = in_a[i] for i<eff_a, otherwise in_a[eff_a-1]. Same rule for B with eff_b.
  - eff_out = eff_a + eff_b.
  - res_mask bit k = 1 iff k < eff_out-4. eff_out<=4 gives all zeros; eff_out=MAC_OUT_WIDTH gives all ones.
  - appr_mask = ~level.
- Buffer: 2-entry FIFO of {a, b, res_mask, appr_mask}.
  - Latency: 1 cycle from in handshake to out_valid on an empty buffer.
  - Full throughput at 1 beat/cycle when out_ready is held high.
  - Simultaneous push and pop on a full buffer is allowed: occupancy stays 2, order preserved.
  - out_* hold stable while out_valid && !out_ready.
- beat_cnt increments on each out_valid && out_ready. It is not reset by reconfiguration.
- Reset mid-stream: the buffer is discarded and no further out_valid occurs until a new config is accepted and new beats arrive.

Decomposition:
- Package appr_pkg:
  - MAC_IN_WIDTH, N_BIT_APPR, N_BIT_RES constants.
  - typedef cfg_t {eff_a, eff_b, level}.
  - typedef beat_t {a, b, res_mask, appr_mask}.
  - enum prep_state_e {UNCFG, RUN, DRAIN}.
- One sub-module, appr_skid_fifo: 2-entry valid/ready FIFO of beat_t.

Test Plan:
1. Reset, then cfg eff_a=4, eff_b=4, level=0; in_a=9'h00B, in_b=9'h003, out_ready=1 -> next cycle out_a=9'h1FB, out_b=9'h003, out_res_mask=14'h000F, out_appr_mask=8'hFF, beat_cnt=1.
2. cfg eff 9/9, level=3; in_a=9'h100 -> out_a=9'h100, out_res_mask=14'h3FFF, out_appr_mask=8'hFC.
3. cfg eff_a=0, eff_b=12 -> cfg_err=1, both widths stored as 9, out_res_mask=14'h3FFF.
4. out_ready=0, 3 beats offered -> 2 accepted, in_ready=0 on the third; release out_ready -> 3 beats out in order, out_* stable while stalled.
5. cfg_valid while occupancy=2 -> DRAIN, in_ready=0; after 2 pops cfg_ready=1 and the new masks apply only to later beats.
6. rst_n low mid-stream with occupancy=1 -> out_valid=0 immediately, in_ready=0, beat_cnt=0, state UNCFG.

Source files
------------

// File: rtl/appr_pkg.sv
// Shared types, widths and helper functions for the appr_mac_prep operand preparation stage.
//   cfg_t        : stored runtime configuration (effective widths, approximation level)
//   beat_t       : one prepared operand beat handed to the multiplier
//   prep_state_e : control state of the preparation stage
package appr_pkg;

  localparam int unsigned MAC_IN_WIDTH  = 9;
  localparam int unsigned N_BIT_APPR    = 8;
  localparam int unsigned N_BIT_RES     = 14;
  localparam int unsigned MAC_OUT_WIDTH = 2 * MAC_IN_WIDTH;
  localparam int unsigned EFF_W         = 4;
  localparam int unsigned EFF_OUT_W     = 5;

  typedef struct packed {
    logic [EFF_W-1:0]      eff_a;
    logic [EFF_W-1:0]      eff_b;
    logic [N_BIT_APPR-1:0] level;
  } cfg_t;

  typedef struct packed {
    logic [MAC_IN_WIDTH-1:0] a;
    logic [MAC_IN_WIDTH-1:0] b;
    logic [N_BIT_RES-1:0]    res_mask;
    logic [N_BIT_APPR-1:0]   appr_mask;
  } beat_t;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } prep_state_e;

  // Width outside 1..MAC_IN_WIDTH cannot be represented by the multiplier
  function automatic logic eff_illegal(input logic [EFF_W-1:0] eff);
    return (eff == '0) || (eff > EFF_W'(MAC_IN_WIDTH));
  endfunction

  function automatic logic [EFF_W-1:0] clamp_eff(input logic [EFF_W-1:0] eff);
    return eff_illegal(eff) ? EFF_W'(MAC_IN_WIDTH) : eff;
  endfunction

  // Replicate bit eff-1 into all higher positions; s tracks the last in-range bit
  function automatic logic [MAC_IN_WIDTH-1:0] sign_ext(input logic [MAC_IN_WIDTH-1:0] x,
                                                       input logic [EFF_W-1:0]        eff);
    logic [MAC_IN_WIDTH-1:0] r;
    logic                    s;
    r = '0;
    s = 1'b0;
    for (int unsigned i = 0; i < MAC_IN_WIDTH; i++) begin
      if (i < 32'(eff)) begin
        r[i] = x[i];
        s    = x[i];
      end else begin
        r[i] = s;
      end
    end
    return r;
  endfunction

  // Bit k set iff k < eff_out-4, written as k+4 < eff_out to avoid underflow
  function automatic logic [N_BIT_RES-1:0] res_mask_of(input logic [EFF_OUT_W-1:0] eff_out);
    logic [N_BIT_RES-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < N_BIT_RES; k++) begin
      m[k] = ((k + 32'd4) < 32'(eff_out));
    end
    return m;
  endfunction

endpackage

// File: rtl/appr_skid_fifo.sv
// Two-entry valid/ready FIFO of beat_t; output data comes straight from storage registers.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data (ignored when full unless popping the same cycle)
//   i_pop      : consumer accepted the head beat
//   o_valid    : head beat present
//   o_data     : head beat
//   o_count    : occupancy 0..2
module appr_skid_fifo
  import appr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  beat_t      i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output beat_t      o_data,
  output logic [1:0] o_count
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // When full, the slot being written is the one being read out this cycle
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/appr_mac_prep.sv
// Operand/mask preparation stage ahead of the approximate multiplier.
// Latches a runtime config, sign-extends operands from their effective widths and
// attaches res/appr masks to each beat, buffered in a 2-entry FIFO.
//   cfg_*    : configuration handshake and sticky clamp error
//   in_*     : raw operand stream
//   out_*    : prepared beat stream to the multiplier
//   beat_cnt : delivered beats, wraps at 2^32
module appr_mac_prep
  import appr_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [EFF_W-1:0]        cfg_eff_a,
  input  logic [EFF_W-1:0]        cfg_eff_b,
  input  logic [N_BIT_APPR-1:0]   cfg_level,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MAC_IN_WIDTH-1:0] in_a,
  input  logic [MAC_IN_WIDTH-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MAC_IN_WIDTH-1:0] out_a,
  output logic [MAC_IN_WIDTH-1:0] out_b,
  output logic [N_BIT_RES-1:0]    out_res_mask,
  output logic [N_BIT_APPR-1:0]   out_appr_mask,
  output logic [31:0]             beat_cnt
);

  prep_state_e          r_state;
  prep_state_e          w_state_next;
  cfg_t                 r_cfg;
  logic                 r_cfg_err;
  logic [31:0]          r_beat_cnt;
  logic                 w_cfg_load;
  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_occ;
  logic [EFF_OUT_W-1:0] w_eff_out;
  beat_t                w_beat_in;
  beat_t                w_beat_out;

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= UNCFG;
    else        r_state <= w_state_next;
  end

  // Next state and handshake readiness
  always_comb begin
    w_state_next = r_state;
    cfg_ready    = 1'b0;
    in_ready     = 1'b0;
    w_cfg_load   = 1'b0;
    case (r_state)
      UNCFG: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_cfg_load   = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        in_ready  = (w_occ < 2'd2);
        cfg_ready = (w_occ == 2'd0);
        if (cfg_valid) begin
          if (w_occ == 2'd0) w_cfg_load   = 1'b1;
          else               w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the buffer will be empty next cycle so cfg_ready rises then
        if ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop)) w_state_next = RUN;
      end
      default: w_state_next = UNCFG;
    endcase
  end

  // Stored configuration and sticky clamp error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg.eff_a <= EFF_W'(MAC_IN_WIDTH);
      r_cfg.eff_b <= EFF_W'(MAC_IN_WIDTH);
      r_cfg.level <= '0;
      r_cfg_err   <= 1'b0;
    end else if (w_cfg_load) begin
      r_cfg.eff_a <= clamp_eff(cfg_eff_a);
      r_cfg.eff_b <= clamp_eff(cfg_eff_b);
      r_cfg.level <= cfg_level;
      r_cfg_err   <= r_cfg_err | eff_illegal(cfg_eff_a) | eff_illegal(cfg_eff_b);
    end
  end

  // Beat preparation from the currently stored config
  assign w_eff_out           = EFF_OUT_W'(r_cfg.eff_a) + EFF_OUT_W'(r_cfg.eff_b);
  assign w_beat_in.a         = sign_ext(in_a, r_cfg.eff_a);
  assign w_beat_in.b         = sign_ext(in_b, r_cfg.eff_b);
  assign w_beat_in.res_mask  = res_mask_of(w_eff_out);
  assign w_beat_in.appr_mask = ~r_cfg.level;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  appr_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_beat_in),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_data  (w_beat_out),
    .o_count (w_occ)
  );

  // Delivered beat counter, survives reconfiguration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_beat_cnt <= 32'd0;
    else if (w_pop) r_beat_cnt <= r_beat_cnt + 32'd1;
  end

  assign out_a         = w_beat_out.a;
  assign out_b         = w_beat_out.b;
  assign out_res_mask  = w_beat_out.res_mask;
  assign out_appr_mask = w_beat_out.appr_mask;
  assign cfg_err       = r_cfg_err;
  assign beat_cnt      = r_beat_cnt;

endmodule
